// File: rtl/osc_phase_detector_pkg.sv
// ============================================================================
//  Module   : osc_phase_detector_pkg
//  Brief    : Shared constants and state encoding for the oscillator phase detector
//  Revision : 1.0
// ============================================================================
`default_nettype none

package osc_phase_detector_pkg;

    localparam int c_N_PHASE = 16;
    localparam int c_PHASE_W = $clog2(c_N_PHASE);
    localparam int c_PHI_W   = 16;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_TRACK  = 2'd1,
        ST_LOCKED = 2'd2
    } state_t;

endpackage

`default_nettype wire

// File: rtl/osc_phase_detector_if.sv
// ============================================================================
//  Module   : osc_phase_detector_if
//  Brief    : Tick/waveform inputs and decoded phase/status outputs
//  Revision : 1.0
// ============================================================================
`default_nettype none

interface osc_phase_detector_if;
    import osc_phase_detector_pkg::*;

    logic               slow_tick;
    logic               nin;
    logic [c_PHI_W-1:0] phi_in;
    logic               phase_valid;
    logic               locked;
    logic               period_err;
    logic               lost;

    modport master (
        output slow_tick, nin,
        input  phi_in, phase_valid, locked, period_err, lost
    );

    modport slave (
        input  slow_tick, nin,
        output phi_in, phase_valid, locked, period_err, lost
    );

endinterface

`default_nettype wire

// File: rtl/osc_phase_detector_nin_sync.sv
// ============================================================================
//  Module   : osc_phase_detector_nin_sync
//  Brief    : Multi-flop synchronizer bringing the asynchronous nin into clk
//  Revision : 1.0
// ============================================================================
`default_nettype none

module osc_phase_detector_nin_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_d,
    output logic o_q
);

    logic [SYNC_STAGES-1:0] r_sync;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync <= '0;
        end else begin
            r_sync[0] <= i_d;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                r_sync[i] <= r_sync[i-1];
            end
        end
    end

    assign o_q = r_sync[SYNC_STAGES-1];

endmodule

`default_nettype wire

// File: rtl/osc_phase_detector.sv
// ============================================================================
//  Module   : osc_phase_detector
//  Brief    : Decodes the phase of a slow oscillator against a free-running
//             tick counter and tracks lock to a stable phase
//  Revision : 1.0
// ============================================================================
`default_nettype none

module osc_phase_detector
    import osc_phase_detector_pkg::*;
#(
    parameter int N_PHASE     = c_N_PHASE,
    parameter int SYNC_STAGES = 2,
    parameter int LOCK_COUNT  = 3
) (
    input  logic                 clk,
    input  logic                 rst_n,
    osc_phase_detector_if.slave  bus
);

    localparam int c_PW = $clog2(N_PHASE);
    localparam int c_CW = $clog2(2*N_PHASE + 1);
    localparam int c_MW = $clog2(LOCK_COUNT + 1);

    localparam logic [c_CW-1:0] c_PERIOD_NOM = c_CW'(N_PHASE);
    localparam logic [c_CW-1:0] c_PERIOD_MAX = c_CW'(2*N_PHASE);
    localparam logic [c_CW-1:0] c_HIGH_LO    = c_CW'(N_PHASE/2 - 1);
    localparam logic [c_CW-1:0] c_HIGH_HI    = c_CW'(N_PHASE/2 + 1);
    localparam logic [c_MW-1:0] c_MATCH_MAX  = c_MW'(LOCK_COUNT);

    logic               w_s;
    logic               r_p;
    logic [c_PW-1:0]    r_ref;
    logic [c_CW-1:0]    r_period;
    logic [c_CW-1:0]    r_high;
    logic [c_PW-1:0]    r_last;
    logic [c_MW-1:0]    r_match;
    state_t             r_state;
    logic [c_PHI_W-1:0] r_phi;
    logic               r_valid;
    logic               r_locked;
    logic               r_err;
    logic               r_lost;

    logic               w_rise;
    logic               w_period_ok;
    logic               w_timeout;
    logic               w_same;
    logic [c_MW-1:0]    w_match_inc;
    state_t             w_state_nxt;
    logic [c_MW-1:0]    w_match_nxt;
    logic [c_PW-1:0]    w_last_nxt;
    logic [c_PHI_W-1:0] w_phi_nxt;
    logic               w_valid_nxt;
    logic               w_err_nxt;
    logic               w_lost_nxt;

    osc_phase_detector_nin_sync #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_nin_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .i_d   (bus.nin),
        .o_q   (w_s)
    );

    // Everything below advances only on ticks; nin activity between ticks is invisible.
    assign w_rise      = bus.slow_tick & w_s & ~r_p;
    assign w_period_ok = (r_period == c_PERIOD_NOM) &&
                         (r_high >= c_HIGH_LO) && (r_high <= c_HIGH_HI);
    assign w_timeout   = bus.slow_tick && !w_rise && (r_state != ST_IDLE) &&
                         (r_period == c_PERIOD_MAX - 1'b1);
    assign w_same      = (r_ref == r_last);
    assign w_match_inc = (r_match == c_MATCH_MAX) ? r_match : r_match + 1'b1;

    always_comb begin
        w_state_nxt = r_state;
        w_match_nxt = r_match;
        w_last_nxt  = r_last;
        w_phi_nxt   = r_phi;
        w_valid_nxt = 1'b0;
        w_err_nxt   = 1'b0;
        w_lost_nxt  = 1'b0;

        if (w_rise) begin
            w_last_nxt = r_ref;
            if (r_state == ST_IDLE) begin
                w_state_nxt = ST_TRACK;
                w_match_nxt = '0;
            end else if (w_period_ok) begin
                w_phi_nxt   = {{(c_PHI_W-c_PW){1'b0}}, r_ref};
                w_valid_nxt = 1'b1;
                w_match_nxt = w_same ? w_match_inc : c_MW'(1);
                if ((r_state == ST_TRACK) && (w_match_nxt == c_MATCH_MAX)) begin
                    w_state_nxt = ST_LOCKED;
                end else if ((r_state == ST_LOCKED) && !w_same) begin
                    w_state_nxt = ST_TRACK;
                end
            end else begin
                w_err_nxt   = 1'b1;
                w_match_nxt = '0;
                w_state_nxt = ST_TRACK;
            end
        end else if (w_timeout) begin
            w_state_nxt = ST_IDLE;
            w_lost_nxt  = 1'b1;
            w_match_nxt = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_p      <= 1'b0;
            r_ref    <= '0;
            r_period <= '0;
            r_high   <= '0;
            r_last   <= '0;
            r_match  <= '0;
            r_phi    <= '0;
            r_valid  <= 1'b0;
            r_locked <= 1'b0;
            r_err    <= 1'b0;
            r_lost   <= 1'b0;
        end else begin
            r_last   <= w_last_nxt;
            r_match  <= w_match_nxt;
            r_phi    <= w_phi_nxt;
            r_valid  <= w_valid_nxt;
            r_locked <= (w_state_nxt == ST_LOCKED);
            r_err    <= w_err_nxt;
            r_lost   <= w_lost_nxt;
            if (bus.slow_tick) begin
                r_p   <= w_s;
                r_ref <= r_ref + 1'b1;
                if (w_rise) begin
                    r_period <= c_CW'(1);
                    r_high   <= c_CW'(1);
                end else begin
                    if (r_period != c_PERIOD_MAX) r_period <= r_period + 1'b1;
                    if (w_s && (r_high != c_PERIOD_MAX)) r_high <= r_high + 1'b1;
                end
            end
        end
    end

    assign bus.phi_in      = r_phi;
    assign bus.phase_valid = r_valid;
    assign bus.locked      = r_locked;
    assign bus.period_err  = r_err;
    assign bus.lost        = r_lost;

endmodule

`default_nettype wire

// File: doc/osc_phase_detector.md
OSC_PHASE_DETECTOR -- requirements
Module: osc_phase_detector

Interface
REQ-001 Parameter N_PHASE, default 16, phase steps per oscillator period (power of 2; code width log2(N_PHASE)=4).
REQ-002 Parameter SYNC_STAGES, default 2, flops in the nin synchronizer.
REQ-003 Parameter LOCK_COUNT, default 3, consecutive equal-phase valid periods required to assert locked.
REQ-004 Port clk, input, 1, single system clock; all logic on posedge clk.
REQ-005 Port rst_n, input, 1, asynchronous active-low reset.
REQ-006 Port slow_tick, input, 1, one-clk-wide phase-step strobe in the clk domain, spaced at least SYNC_STAGES+2 clk cycles apart.
REQ-007 Port nin, input, 1, asynchronous oscillator waveform to be decoded (nominal N_PHASE/2 ticks high, N_PHASE/2 low).
REQ-008 Port phi_in, output, 16, decoded phase: {12'b0, phase[3:0]}.
REQ-009 Port phase_valid, output, 1, one-clk pulse when phi_in is updated from a valid period.
REQ-010 Port locked, output, 1, high while LOCKED.
REQ-011 Port period_err, output, 1, one-clk pulse on a malformed period.
REQ-012 Port lost, output, 1, one-clk pulse on edge timeout.

Function
REQ-013 nin passes through SYNC_STAGES flops; synchronized value s is sampled only on slow_tick.
REQ-014 ref_cnt (4 bits) increments on every slow_tick, wraps 15->0, free-running in all states.
REQ-015 Rise = tick where sampled s=1 and previous tick's sample p=0; captured phase = ref_cnt value before that tick's increment.
REQ-016 period_cnt counts ticks since last rise (set to 1 on rise tick); high_cnt counts ticks with s=1 since last rise (rise tick counts as 1).
REQ-017 States IDLE, TRACK, LOCKED; IDLE after reset.
REQ-018 IDLE: on rise -> TRACK, store phase as last_phase, match_cnt=0; no outputs pulsed.
REQ-019 TRACK/LOCKED on rise, period valid iff period_cnt==N_PHASE and high_cnt in N_PHASE/2-1..N_PHASE/2+1.
REQ-020 Valid period: phi_in <= {12'b0, phase}, phase_valid pulse; match_cnt <= (phase==last_phase) ? saturating match_cnt+1 : 1; last_phase <= phase.
REQ-021 TRACK -> LOCKED when updated match_cnt==LOCK_COUNT; LOCKED -> TRACK when a valid period has phase!=last_phase.
REQ-022 Invalid period: period_err pulse, match_cnt=0, state TRACK, phi_in unchanged, last_phase <= phase.
REQ-023 Timeout: period_cnt reaches 2*N_PHASE without rise -> IDLE, lost pulse, match_cnt=0; a rise on that same tick is instead handled as invalid period (REQ-022).
REQ-024 period_cnt and high_cnt saturate at 2*N_PHASE; no wrap.
REQ-025 All pulses and phi_in/locked updates registered: visible on the clk cycle after the slow_tick cycle that caused them.
REQ-026 nin changes between ticks never produce events; only tick samples matter.

Reset
REQ-027 rst_n low asynchronously forces: state IDLE, ref_cnt=0, sync flops=0, p=0, counters=0, last_phase=0, phi_in=0, phase_valid=0, locked=0, period_err=0, lost=0.
REQ-028 Reset asserted mid-period discards all measurement; first rise after release only re-enters TRACK.

Structure
REQ-029 Shared package holds N_PHASE default, phase-code width, state enum (IDLE/TRACK/LOCKED).
REQ-030 Sub-module nin_sync (SYNC_STAGES-deep synchronizer) is instantiated; rest is one module.

Verification
REQ-031 Reset, ideal nin rising at ref_cnt=5, 8 high/8 low: first rise no pulse; next rise phase_valid, phi_in=16'h0005; locked high after 3rd valid period.
REQ-032 Locked at phase 5, nin shifted to rise at ref_cnt=9 (period 20): period_err, locked drops; next valid period phi_in=16'h0009, match restart.
REQ-033 nin held 0 for 32 ticks after a rise: lost pulse, state IDLE, locked=0, phi_in retains last value.
REQ-034 Period 16 with high width 5: period_err each period, phase_valid never pulses.
REQ-035 Glitch on nin between ticks (1 clk wide, no tick): no pulses, counters unchanged.
REQ-036 rst_n low while LOCKED: all outputs 0 immediately, re-lock needs 1 rise + 3 valid periods.
